// File: rtl/serial_sub10.sv
// Bit-serial subtractor: diff = sum_in - a_in, one full-adder slice reused LSB first.
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 on borrow and to all ones on overflow.
module serial_sub10 #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum_in,
    input  logic [WIDTH-1:0] a_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned CW = $clog2(SW + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   sum_sr;
    logic [SW-1:0]   a_sr;
    logic [SW-1:0]   res;
    logic [CW-1:0]   cnt;
    logic            carry;

    logic            a_inv_c;
    logic            d_bit_c;
    logic            carry_nxt_c;
    logic [SW-1:0]   res_nxt_c;
    logic [WIDTH-1:0] diff_fin_c;

    // Full-adder slice on the current LSBs; a is inverted for two's-complement subtraction
    always_comb begin
        a_inv_c     = ~a_sr[0];
        d_bit_c     = sum_sr[0] ^ a_inv_c ^ carry;
        carry_nxt_c = (sum_sr[0] & a_inv_c) | (sum_sr[0] & carry) | (a_inv_c & carry);
        res_nxt_c   = {d_bit_c, res[SW-1:1]};
    end

    // Final diff as seen on the last RUN cycle, before it is registered
    always_comb begin
        diff_fin_c = res_nxt_c[WIDTH-1:0];
`ifdef SERIAL_SUB_SAT_EN
        if (!carry_nxt_c) begin
            diff_fin_c = '0;
        end else if (res_nxt_c[WIDTH]) begin
            diff_fin_c = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            sum_sr    <= '0;
            a_sr      <= '0;
            res       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sum_sr   <= sum_in;
                        a_sr     <= {1'b0, a_in};
                        res      <= '0;
                        carry    <= 1'b1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_sr <= sum_sr >> 1;
                    a_sr   <= a_sr >> 1;
                    carry  <= carry_nxt_c;
                    res    <= res_nxt_c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH)) begin
                        diff      <= diff_fin_c;
                        borrow    <= ~carry_nxt_c;
                        overflow  <= carry_nxt_c & res_nxt_c[WIDTH];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
